// File: rtl/regfile_issue_if.sv
// ---------------------------------------------------------------------------
// regfile_issue_if
// Bundles the decode, operand, execute-result and writeback signals of
// regfile_issue. clk and reset stay plain ports on the module.
//   master : the pipeline side (drives decode/exec/flush, observes outputs)
//   slave  : regfile_issue itself
// Signals:
//   flush                                  abort in-flight instruction
//   decode_valid / decode_ready            instruction offer / accept
//   decode_rs1 / decode_rs2 / decode_rd    register indices
//   decode_writes_rd                       instruction writes rd
//   read_rs1_val / read_rs2_val/read_valid operands to execute units
//   exec_valid / exec_rd_val               execute result
//   wb_valid / wb_rd / wb_val              register write this cycle
//   timeout_err                            WAIT timeout pulse
// ---------------------------------------------------------------------------
interface regfile_issue_if;
    logic        flush;
    logic        decode_valid;
    logic        decode_ready;
    logic [4:0]  decode_rs1;
    logic [4:0]  decode_rs2;
    logic [4:0]  decode_rd;
    logic        decode_writes_rd;
    logic [31:0] read_rs1_val;
    logic [31:0] read_rs2_val;
    logic        read_valid;
    logic        exec_valid;
    logic [31:0] exec_rd_val;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_val;
    logic        timeout_err;

    modport master (
        output flush, decode_valid, decode_rs1, decode_rs2, decode_rd,
               decode_writes_rd, exec_valid, exec_rd_val,
        input  decode_ready, read_rs1_val, read_rs2_val, read_valid,
               wb_valid, wb_rd, wb_val, timeout_err
    );

    modport slave (
        input  flush, decode_valid, decode_rs1, decode_rs2, decode_rd,
               decode_writes_rd, exec_valid, exec_rd_val,
        output decode_ready, read_rs1_val, read_rs2_val, read_valid,
               wb_valid, wb_rd, wb_val, timeout_err
    );
endinterface

// File: rtl/regfile_issue.sv
// ---------------------------------------------------------------------------
// regfile_issue
// 32x32 register file with a single-instruction-in-flight issue FSM
// (IDLE -> ISSUE -> [WAIT] -> IDLE). x0 reads as zero and ignores writes.
// Ports:
//   clk    single clock, all state on posedge
//   reset  synchronous, active-high; clears registers and aborts work
//   bus    regfile_issue_if.slave (decode, operands, execute result,
//          writeback, timeout_err)
// Parameter:
//   TIMEOUT_CYCLES  max WAIT cycles before abort (timeout build only)
// Optional feature:
//   REGFILE_ISSUE_TIMEOUT_EN  when defined, a WAIT-cycle counter aborts the
//   instruction after TIMEOUT_CYCLES WAIT cycles and pulses timeout_err.
//   When undefined, timeout_err is tied 0 and WAIT persists.
// ---------------------------------------------------------------------------
module regfile_issue #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic           clk,
    input logic           reset,
    regfile_issue_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] regs [32];
    logic [4:0]  cap_rd;
    logic        cap_writes;
    logic [31:0] op1;
    logic [31:0] op2;

    logic        accept;
    logic        in_flight;
    logic        complete;
    logic        do_write;
    logic        timeout_hit;

    // A non-positive timeout is meaningless; stop elaboration early.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("regfile_issue: TIMEOUT_CYCLES must be >= 1");
    end

    // Handshake and completion qualifiers. Flush kills both acceptance and
    // completion in the cycle it is asserted.
    always_comb begin
        accept    = (state == IDLE) && bus.decode_valid && !bus.flush && !reset;
        in_flight = (state == ISSUE) || (state == WAIT);
        complete  = in_flight && bus.exec_valid && !bus.flush && !reset;
        do_write  = complete && cap_writes && (cap_rd != 5'd0);
    end

`ifdef REGFILE_ISSUE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;

    // Counts WAIT cycles: zero in the first WAIT cycle, so the abort lands
    // on the TIMEOUT_CYCLES-th WAIT cycle. A result in that cycle still wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        timeout_hit = (state == WAIT) && !bus.exec_valid && !bus.flush &&
                      !reset && (wait_cnt == LAST_WAIT);
    end
`else
    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    // Next-state logic; reset is applied in the state register.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.flush || bus.exec_valid) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush || bus.exec_valid || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, capture and register-file update. Accept and write never
    // coincide (different states), so an operand read always sees the
    // value written at an earlier edge and no bypass is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cap_rd     <= '0;
            cap_writes <= 1'b0;
            op1        <= '0;
            op2        <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                cap_rd     <= bus.decode_rd;
                cap_writes <= bus.decode_writes_rd;
                op1        <= regs[bus.decode_rs1];
                op2        <= regs[bus.decode_rs2];
            end
            if (do_write) begin
                regs[cap_rd] <= bus.exec_rd_val;
            end
        end
    end

    // Outputs are forced quiet while reset is held.
    always_comb begin
        bus.decode_ready = !reset && (state == IDLE) && !bus.flush;
        bus.read_valid   = !reset && (state == ISSUE);
        bus.read_rs1_val = reset ? 32'd0 : op1;
        bus.read_rs2_val = reset ? 32'd0 : op2;
        bus.wb_valid     = do_write;
        bus.wb_rd        = do_write ? cap_rd : 5'd0;
        bus.wb_val       = do_write ? bus.exec_rd_val : 32'd0;
        bus.timeout_err  = timeout_hit;
    end

endmodule

// File: tb/tb_regfile_issue.sv
// ---------------------------------------------------------------------------
// tb_regfile_issue
// Testbench for regfile_issue: directed scenarios with literal expectations
// followed by randomized traffic, with a transaction-level reference model
// checked against every output each cycle.
// Honours REGFILE_ISSUE_TIMEOUT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_regfile_issue;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_issue_if bus ();

    regfile_issue #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit model_ok = 1'b0;

    // Reference model: age 0 = nothing in flight, 1 = operand cycle,
    // n >= 2 = (n-1)-th cycle spent waiting for a result.
    int          age = 0;
    logic [4:0]  m_rd = '0;
    bit          m_wr = 1'b0;
    logic [31:0] m_op1 = '0;
    logic [31:0] m_op2 = '0;
    logic [31:0] m_regs [32];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual 0x%08h required 0x%08h",
                     name, cycle, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit fl, input bit dv,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input bit wr,
                                 input bit ev, input logic [31:0] val);
        @(posedge clk);
        #1;
        reset                = rst;
        bus.flush            = fl;
        bus.decode_valid     = dv;
        bus.decode_rs1       = rs1;
        bus.decode_rs2       = rs2;
        bus.decode_rd        = rd;
        bus.decode_writes_rd = wr;
        bus.exec_valid       = ev;
        bus.exec_rd_val      = val;
        #1;
    endtask

    // Compare the DUT against the model at mid-cycle, then advance the model
    // to what the coming edge must produce.
    always @(negedge clk) begin
        bit          e_ready;
        bit          e_rv;
        bit          comp;
        bit          tmo;
        bit          wr;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        cycle++;
        e_ready = !reset && age == 0 && !bus.flush;
        e_rv    = !reset && age == 1;
        e_op1   = reset ? 32'd0 : m_op1;
        e_op2   = reset ? 32'd0 : m_op2;
        comp    = !reset && !bus.flush && age > 0 && bus.exec_valid;
`ifdef REGFILE_ISSUE_TIMEOUT_EN
        tmo     = !reset && !bus.flush && !bus.exec_valid && age == TO + 1;
`else
        tmo     = 1'b0;
`endif
        wr      = comp && m_wr && m_rd != 5'd0;
        if (model_ok) begin
            checkOutput("cmp_decode_ready", 32'(bus.decode_ready), 32'(e_ready));
            checkOutput("cmp_read_valid", 32'(bus.read_valid), 32'(e_rv));
            checkOutput("cmp_read_rs1_val", bus.read_rs1_val, e_op1);
            checkOutput("cmp_read_rs2_val", bus.read_rs2_val, e_op2);
            checkOutput("cmp_wb_valid", 32'(bus.wb_valid), 32'(wr));
            checkOutput("cmp_wb_rd", 32'(bus.wb_rd), wr ? 32'(m_rd) : 32'd0);
            checkOutput("cmp_wb_val", bus.wb_val, wr ? bus.exec_rd_val : 32'd0);
            checkOutput("cmp_timeout_err", 32'(bus.timeout_err), 32'(tmo));
        end
        if (reset) begin
            model_ok = 1'b1;
            age   = 0;
            m_rd  = '0;
            m_wr  = 1'b0;
            m_op1 = '0;
            m_op2 = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else begin
            if (wr) m_regs[m_rd] = bus.exec_rd_val;
            if (age > 0) begin
                if (bus.flush || comp || tmo) age = 0;
                else age = age + 1;
            end else if (bus.decode_valid && !bus.flush) begin
                m_rd  = bus.decode_rd;
                m_wr  = bus.decode_writes_rd;
                m_op1 = m_regs[bus.decode_rs1];
                m_op2 = m_regs[bus.decode_rs2];
                age   = 1;
            end
        end
    end

    initial begin
        reset                = 1'b1;
        bus.flush            = 1'b0;
        bus.decode_valid     = 1'b0;
        bus.decode_rs1       = '0;
        bus.decode_rs2       = '0;
        bus.decode_rd        = '0;
        bus.decode_writes_rd = 1'b0;
        bus.exec_valid       = 1'b0;
        bus.exec_rd_val      = '0;

        $display("[TB] reset and basic issue/writeback");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 3, 3, 3, 1, 1, 32'h55);
        checkOutput("rst_decode_ready", 32'(bus.decode_ready), 0);
        checkOutput("rst_read_valid", 32'(bus.read_valid), 0);
        checkOutput("rst_wb_valid", 32'(bus.wb_valid), 0);
        checkOutput("rst_read_rs1_val", bus.read_rs1_val, 0);

        applyStimulus(0, 0, 1, 0, 0, 5, 1, 0, 0);
        checkOutput("idle_ready", 32'(bus.decode_ready), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("issue_read_valid", 32'(bus.read_valid), 1);
        checkOutput("issue_op1_zero", bus.read_rs1_val, 0);
        checkOutput("issue_op2_zero", bus.read_rs2_val, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
        checkOutput("wait_wb_valid", 32'(bus.wb_valid), 1);
        checkOutput("wait_wb_rd", 32'(bus.wb_rd), 5);
        checkOutput("wait_wb_val", bus.wb_val, 32'h1234);

        $display("[TB] same-cycle execute and x0 handling");
        applyStimulus(0, 0, 1, 5, 0, 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA);
        checkOutput("same_cycle_rv", 32'(bus.read_valid), 1);
        checkOutput("same_cycle_op1", bus.read_rs1_val, 32'h1234);
        checkOutput("no_wr_wb_valid", 32'(bus.wb_valid), 0);
        applyStimulus(0, 0, 1, 5, 5, 0, 1, 0, 0);
        checkOutput("no_wait_ready", 32'(bus.decode_ready), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        checkOutput("x0_op2", bus.read_rs2_val, 32'h1234);
        checkOutput("x0_wb_valid", 32'(bus.wb_valid), 0);

        $display("[TB] flush against execute result");
        applyStimulus(0, 0, 1, 0, 5, 7, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_reads_zero", bus.read_rs1_val, 0);
        checkOutput("rs2_x5", bus.read_rs2_val, 32'h1234);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 32'hDEAD);
        checkOutput("flush_wb_valid", 32'(bus.wb_valid), 0);
        checkOutput("flush_ready", 32'(bus.decode_ready), 0);
        applyStimulus(0, 0, 1, 7, 0, 0, 0, 0, 0);
        checkOutput("after_flush_ready", 32'(bus.decode_ready), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("x7_unchanged", bus.read_rs1_val, 0);

        $display("[TB] long WAIT");
        applyStimulus(0, 0, 1, 0, 0, 9, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef REGFILE_ISSUE_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("timeout_err", 32'(bus.timeout_err), (i == TO) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("timeout_idle", 32'(bus.decode_ready), 1);
`else
        for (int i = 1; i <= 200; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("wait_persist", 32'(bus.decode_ready), 0);
            checkOutput("no_timeout", 32'(bus.timeout_err), 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555);
        checkOutput("late_wb_valid", 32'(bus.wb_valid), 1);
        checkOutput("late_wb_rd", 32'(bus.wb_rd), 9);
`endif

        $display("[TB] reset during WAIT");
        applyStimulus(0, 0, 1, 0, 0, 10, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 32'h7777);
        checkOutput("rst_prio_wb", 32'(bus.wb_valid), 0);
        checkOutput("rst_prio_ready", 32'(bus.decode_ready), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h7777);
        checkOutput("post_rst_wb", 32'(bus.wb_valid), 0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 0, 1, 5'(2 * k), 5'(2 * k + 1), 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
            checkOutput("sweep_rv", 32'(bus.read_valid), 1);
            checkOutput("sweep_op1", bus.read_rs1_val, 0);
            checkOutput("sweep_op2", bus.read_rs2_val, 0);
        end

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 79) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) < 7,
                          5'($urandom), 5'($urandom), 5'($urandom),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) < 4,
                          $urandom);
        end

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_issue.md
REGFILE_ISSUE -- requirements
Module: regfile_issue

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max WAIT cycles before abort; used only with REGFILE_ISSUE_TIMEOUT_EN.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  abort in-flight instruction.
REQ-005 decode_valid  input  1  decoded instruction offered.
REQ-006 decode_ready  output  1  block accepts an instruction this cycle.
REQ-007 decode_rs1 / decode_rs2 / decode_rd  input  5 each  register indices.
REQ-008 decode_writes_rd  input  1  instruction writes rd.
REQ-009 read_rs1_val / read_rs2_val  output  32 each  operands to execute units.
REQ-010 read_valid  output  1  one-cycle operand-present pulse to execute units.
REQ-011 exec_valid  input  1  execute result present.
REQ-012 exec_rd_val  input  32  execute result value.
REQ-013 wb_valid  output  1  register write performed this cycle.
REQ-014 wb_rd  output  5  written register index.
REQ-015 wb_val  output  32  written value.
REQ-016 timeout_err  output  1  one-cycle pulse on WAIT timeout.

Function
REQ-017 Block SHALL hold a 32x32 register file; x0 SHALL always read 0 and ignore writes.
REQ-018 FSM states SHALL be IDLE, ISSUE and WAIT; decode_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, decode_valid=1 with flush=0 SHALL capture rd/decode_writes_rd, register rs1/rs2 values and move to ISSUE next cycle.
REQ-020 In ISSUE, read_valid SHALL be 1 for exactly that one cycle with the captured operand values; operands SHALL hold until next accept.
REQ-021 In ISSUE, exec_valid=1 in the same cycle SHALL complete the instruction (same-cycle execute result) and return to IDLE; otherwise the FSM SHALL go to WAIT.
REQ-022 In WAIT, exec_valid=1 SHALL complete the instruction and return to IDLE; exec_valid SHALL be ignored in IDLE.
REQ-023 Completion with decode_writes_rd=1 and rd!=0 SHALL write exec_rd_val to rd at that clock edge and pulse wb_valid with wb_rd/wb_val for that same cycle (combinational from the completing inputs).
REQ-024 Completion with decode_writes_rd=0 or rd=0 SHALL return to IDLE without write and with wb_valid=0.
REQ-025 Operand read in the cycle after a write SHALL return the new value; the one-in-flight rule means no bypass is required.
REQ-026 flush=1 in any state SHALL force IDLE next cycle, suppress the write and wb_valid, and block decode acceptance that cycle; flush wins over simultaneous exec_valid.
REQ-027 read_valid SHALL be 0 in IDLE and WAIT.

Reset
REQ-028 reset=1 SHALL force IDLE and clear all 32 registers, captured rd and operands to 0.
REQ-029 While reset=1, outputs SHALL be decode_ready=0, read_valid=0, wb_valid=0 and timeout_err=0, with all data outputs 0; reset SHALL take priority over flush and exec_valid.
REQ-030 reset mid-WAIT SHALL discard the instruction; a later exec_valid SHALL cause no write.

Configuration
REQ-031 With REGFILE_ISSUE_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-032 Reaching TIMEOUT_CYCLES without exec_valid SHALL pulse timeout_err for one cycle, skip the write and return to IDLE.
REQ-033 Without REGFILE_ISSUE_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied 0, and WAIT SHALL persist until exec_valid, flush or reset.

Verification
REQ-034 After reset, issue rs1=0, rs2=0 -> read_valid pulse with both operands 0; exec_valid with 0x1234, rd=5 -> wb_valid, wb_rd=5, wb_val=0x1234.
REQ-035 Issue rs1=5; exec_valid in the same cycle as read_valid -> no WAIT, and decode_ready=1 next cycle. Next issue rs1=5 -> read_rs1_val=0x1234.
REQ-036 Issue rd=0 and return exec_valid with 0xFFFFFFFF -> wb_valid=0, and a later read of x0 returns 0.
REQ-037 Flush and exec_valid in the same WAIT cycle with rd=7 -> no write, x7 unchanged and IDLE next cycle.
REQ-038 Enter WAIT with no exec_valid and REGFILE_ISSUE_TIMEOUT_EN defined -> timeout_err pulses after 64 WAIT cycles and the FSM returns to IDLE. Macro undefined -> FSM stays in WAIT for 200 cycles.
REQ-039 Assert reset mid-WAIT, then exec_valid -> no wb_valid, all registers read 0.
